ex_result_buffer: RTL and testbench
===================================

// Module: ex_result_buffer
// PURPOSE
//  Execute-to-memory pipeline stage directly downstream of the 32-bit ALU.
//  Captures ALU result, zero/negative/overflow flags and writeback tags into a
//  2-entry skid buffer with valid/ready handshakes, so a memory-stage stall never
//  drops or duplicates an ALU op. Holds the architectural flag register (Z,N,V)
//  used by branch resolution. Counts downstream stall cycles for perf analysis.
// PARAMETERS
//  DATA_W  32  width of ALU result / out_result
//  REG_AW  5   width of destination register index
//  CNT_W   16  width of saturating stall counter
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  in_valid       in   1       upstream op valid this cycle
//  in_ready       out  1       stage can accept; transfer when in_valid&&in_ready
//  in_result      in   DATA_W  ALU result
//  in_zero        in   1       ALU zero_flag
//  in_neg         in   1       ALU negative_flag
//  in_ovf         in   1       ALU overflow_flag
//  in_rd          in   REG_AW  destination register index
//  in_reg_write   in   1       op writes register file
//  in_flag_write  in   1       op updates flag register
//  flush          in   1       discard all buffered and incoming ops
//  out_valid      out  1       head entry valid
//  out_ready      in   1       downstream accepts; pop when out_valid&&out_ready
//  out_result     out  DATA_W  head entry result
//  out_rd         out  REG_AW  head entry destination
//  out_reg_write  out  1       head entry register-write enable
//  flag_z         out  1       architectural zero flag
//  flag_n         out  1       architectural negative flag
//  flag_v         out  1       architectural overflow flag
//  stall_cnt      out  CNT_W   cycles with out_valid && !out_ready
// BEHAVIOUR
//  - Reset (async, rst=1): state EMPTY; out_valid=0; in_ready=1; all data regs,
//    flag_z/n/v and stall_cnt = 0. Reset mid-transfer discards all entries.
//  - States: EMPTY (0 entries), ONE (main valid), FULL (main+skid valid).
//    in_ready = (state!=FULL), from registered state only (no in_valid/out_ready
//    path). out_valid = (state!=EMPTY); out_* driven from main register.
//  - Let acc = in_valid&&in_ready, pop = out_valid&&out_ready (flush=0):
//    EMPTY: acc -> ONE (main<=in).
//    ONE:   acc&&pop -> ONE (main<=in); acc only -> FULL (skid<=in);
//           pop only -> EMPTY; neither -> hold.
//    FULL:  pop -> ONE (main<=skid); else hold. No accept possible.
//  - Latency 1 cycle in->out when empty; throughput 1 op/cycle; strict FIFO order.
//  - Flags: on acc && in_flag_write && !flush, {flag_z,flag_n,flag_v} <=
//    {in_zero,in_neg,in_ovf} next edge (acceptance order, independent of pop).
//    Flags are not stored per entry.
//  - flush=1: next state EMPTY; any simultaneous acc is dropped, including its
//    flag update; pop in that cycle still counts as consumed downstream.
//    stall_cnt unaffected by flush.
//  - stall_cnt: +1 each cycle out_valid && !out_ready; saturates at 2^CNT_W-1.
//  - Entry contents are held stable while out_valid && !out_ready.
// STRUCTURE
//  - Shared package ex_pkg: DATA_W/REG_AW defaults, entry field layout
//    {result, rd, reg_write}, flag bit indices FLAG_Z=2, FLAG_N=1, FLAG_V=0,
//    state encodings EMPTY/ONE/FULL.
//  - One sub-module: pipe_skid2 (generic width 2-entry skid buffer, handshake +
//    state machine); top adds flag register, stall counter, flush gating.
// TESTING
//  - Reset then single op result=0x0000_00FF, rd=3, out_ready=1 -> out_valid 1 cycle
//    later with out_result=0xFF, out_rd=3; in_ready stays 1.
//  - Back-to-back 8 ops, out_ready=1 -> 8 outputs on 8 consecutive cycles, in order.
//  - out_ready=0, push A,B -> in_ready=0 after B, stall_cnt increments; raise
//    out_ready -> A then B out, no loss/duplication, in_ready=1 after A pops.
//  - Accept op flag_write=1 flags (Z,N,V)=(1,0,1), then op flag_write=0 (0,1,0)
//    -> flags stay 1,0,1.
//  - FULL with flush=1 and in_valid=1 -> next cycle out_valid=0, state EMPTY,
//    dropped op's flags not applied.
//  - Hold out_ready=0 for 2^CNT_W+5 cycles -> stall_cnt = 0xFFFF; assert rst
//    mid-stall -> all outputs zero immediately, in_ready=1.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared widths, entry layout, flag bit positions and skid-buffer state codes
package ex_pkg;
  localparam int DATA_W_D = 32;
  localparam int REG_AW_D = 5;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  // An entry is packed as {result, rd, reg_write}.
  function automatic int entry_w(input int dw, input int aw);
    return dw + aw + 1;
  endfunction
endpackage

// File: rtl/pipe_skid2.sv
// pipe_skid2: generic 2-entry skid buffer; in_valid/in_ready/in_data upstream,
// out_valid/out_ready/out_data downstream (head = main register), flush empties it.
module pipe_skid2
  import ex_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [1:0]   r_state;
  logic [1:0]   w_next;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         w_acc;
  logic         w_pop;
  assign in_ready  = r_state != ST_FULL;
  assign out_valid = r_state != ST_EMPTY;
  assign out_data  = r_main;
  assign w_acc     = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  always_comb begin
    w_next = r_state;
    if (flush) w_next = ST_EMPTY;
    else if (r_state == ST_EMPTY) w_next = w_acc ? ST_ONE : ST_EMPTY;
    else if (r_state == ST_ONE) w_next = (w_acc && !w_pop) ? ST_FULL : (!w_acc && w_pop) ? ST_EMPTY : ST_ONE;
    else w_next = w_pop ? ST_ONE : ST_FULL;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_next;
      if (!flush) begin
        // main takes the skid entry on a drain from FULL, otherwise the new op
        // when it becomes (or stays, via pop) the head.
        if (r_state == ST_FULL && w_pop) r_main <= r_skid;
        else if (w_acc && (r_state == ST_EMPTY || w_pop)) r_main <= in_data;
        if (w_acc && r_state == ST_ONE && !w_pop) r_skid <= in_data;
      end
    end
  end
endmodule

// File: rtl/ex_result_buffer.sv
// ex_result_buffer: execute-to-memory stage buffering ALU results with a 2-entry skid buffer.
// Upstream: in_valid/in_ready, in_result, in_zero/in_neg/in_ovf, in_rd, in_reg_write, in_flag_write.
// Downstream: out_valid/out_ready, out_result, out_rd, out_reg_write.
// Control/status: flush, architectural flags flag_z/n/v, saturating stall_cnt.
module ex_result_buffer
  import ex_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int REG_AW = REG_AW_D,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic              in_neg,
  input  logic              in_ovf,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_flag_write,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int EW = entry_w(DATA_W, REG_AW);
  logic [EW-1:0]    w_in_entry;
  logic [EW-1:0]    w_out_entry;
  logic [2:0]       w_flag_in;
  logic [2:0]       r_flags;
  logic [CNT_W-1:0] r_stall;
  logic             w_acc;
  assign w_in_entry = {in_result, in_rd, in_reg_write};
  assign {out_result, out_rd, out_reg_write} = w_out_entry;
  assign w_flag_in[FLAG_Z] = in_zero;
  assign w_flag_in[FLAG_N] = in_neg;
  assign w_flag_in[FLAG_V] = in_ovf;
  assign flag_z    = r_flags[FLAG_Z];
  assign flag_n    = r_flags[FLAG_N];
  assign flag_v    = r_flags[FLAG_V];
  assign stall_cnt = r_stall;
  // Flags follow acceptance order; a flushed op never reaches them.
  assign w_acc = in_valid && in_ready && !flush;
  pipe_skid2 #(.W(EW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_entry)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= '0;
      r_stall <= '0;
    end else begin
      if (w_acc && in_flag_write) r_flags <= w_flag_in;
      if (out_valid && !out_ready && r_stall != '1) r_stall <= r_stall + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ex_result_buffer.sv
// tb_ex_result_buffer: randomized and directed checks against a queue-based reference model
module tb_ex_result_buffer;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0, in_zero = 0, in_neg = 0, in_ovf = 0;
  logic        in_reg_write = 0, in_flag_write = 0, flush = 0, out_ready = 0;
  logic [31:0] in_result = 0;
  logic [4:0]  in_rd = 0;
  logic        in_ready, out_valid, out_reg_write, flag_z, flag_n, flag_v;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic [15:0] stall_cnt;
  typedef struct packed {logic [31:0] r; logic [4:0] rd; logic w;} ent_t;
  ent_t       q[$];
  logic [2:0] m_flags;
  int         m_stall;
  int         n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  ex_result_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_neg(in_neg), .in_ovf(in_ovf), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_flag_write(in_flag_write), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .stall_cnt(stall_cnt)
  );
  task automatic drive(input bit v, input logic [31:0] r, input logic [4:0] rd, input bit rw,
                       input bit fw, input logic [2:0] znv, input bit fl, input bit ordy);
    in_valid = v; in_result = r; in_rd = rd; in_reg_write = rw; in_flag_write = fw;
    {in_zero, in_neg, in_ovf} = znv; flush = fl; out_ready = ordy;
  endtask
  // Advance the model by one cycle using the currently driven inputs, then the DUT.
  task automatic tick();
    bit vld, rdy;
    vld = q.size() > 0;
    rdy = q.size() < 2;
    if (vld && !out_ready && m_stall < 65535) m_stall++;
    if (flush) q.delete();
    else begin
      if (vld && out_ready) void'(q.pop_front());
      if (in_valid && rdy) begin
        q.push_back('{in_result, in_rd, in_reg_write});
        if (in_flag_write) m_flags = {in_zero, in_neg, in_ovf};
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    q.delete();
    m_flags = 0;
    m_stall = 0;
  endtask
  task automatic test_reset();
    do_reset();
    n_vec++; if ({out_valid, out_result, out_rd, out_reg_write} !== 39'd0) begin n_err++; $display("FAIL reset_out got %b/%h/%h/%b want 0", out_valid, out_result, out_rd, out_reg_write); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if ({flag_z, flag_n, flag_v, stall_cnt} !== 19'd0) begin n_err++; $display("FAIL reset_flags_stall got %b%b%b/%h want 0", flag_z, flag_n, flag_v, stall_cnt); end
  endtask
  task automatic test_single();
    do_reset();
    drive(1, 32'h0000_00FF, 3, 1, 0, 0, 0, 1);
    tick();
    n_vec++; if ({out_valid, out_result, out_rd} !== {1'b1, 32'hFF, 5'd3}) begin n_err++; $display("FAIL single_out got %b/%h/%0d want 1/000000ff/3", out_valid, out_result, out_rd); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready got %b want 1", in_ready); end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h100 + i, 5'(i), 1, 0, 0, 0, 1);
      tick();
      n_vec++; if ({out_valid, in_ready, out_result, out_rd} !== {2'b11, 32'h100 + i, 5'(i)}) begin n_err++; $display("FAIL b2b_op%0d got %b%b/%h/%0d want 11/%h/%0d", i, out_valid, in_ready, out_result, out_rd, 32'h100 + i, i); end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask
  task automatic test_stall();
    do_reset();
    drive(1, 32'hAAAA_0001, 1, 1, 0, 0, 0, 0);
    tick();
    drive(1, 32'hBBBB_0002, 2, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if ({in_ready, stall_cnt} !== {1'b0, 16'd1}) begin n_err++; $display("FAIL stall_full got %b/%0d want 0/1", in_ready, stall_cnt); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if ({out_result, stall_cnt} !== {32'hAAAA_0001, 16'd2}) begin n_err++; $display("FAIL stall_hold got %h/%0d want aaaa0001/2", out_result, stall_cnt); end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    n_vec++; if ({out_valid, in_ready, out_result, out_rd, out_reg_write} !== {2'b11, 32'hBBBB_0002, 5'd2, 1'b0}) begin n_err++; $display("FAIL stall_second got %b%b/%h/%0d/%b want 11/bbbb0002/2/0", out_valid, in_ready, out_result, out_rd, out_reg_write); end
    tick();
    n_vec++; if ({out_valid, stall_cnt} !== {1'b0, 16'd2}) begin n_err++; $display("FAIL stall_drain got %b/%0d want 0/2", out_valid, stall_cnt); end
  endtask
  task automatic test_flags();
    do_reset();
    drive(1, 1, 1, 1, 1, 3'b101, 0, 1);
    tick();
    n_vec++; if ({flag_z, flag_n, flag_v} !== 3'b101) begin n_err++; $display("FAIL flags_write got %b%b%b want 101", flag_z, flag_n, flag_v); end
    drive(1, 2, 2, 1, 0, 3'b010, 0, 1);
    tick();
    n_vec++; if ({flag_z, flag_n, flag_v} !== 3'b101) begin n_err++; $display("FAIL flags_nowrite got %b%b%b want 101", flag_z, flag_n, flag_v); end
  endtask
  task automatic test_flush();
    do_reset();
    drive(1, 5, 5, 1, 1, 3'b010, 0, 0);
    tick();
    drive(1, 6, 6, 1, 1, 3'b101, 1, 0);
    tick();
    n_vec++; if ({out_valid, in_ready, flag_z, flag_n, flag_v} !== 5'b01010) begin n_err++; $display("FAIL flush_one got %b%b/%b%b%b want 01/010", out_valid, in_ready, flag_z, flag_n, flag_v); end
    drive(1, 7, 7, 0, 0, 0, 0, 0);
    tick();
    drive(1, 8, 8, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_prefull got %b want 0", in_ready); end
    drive(1, 9, 9, 1, 1, 3'b111, 1, 0);
    tick();
    n_vec++; if ({out_valid, in_ready, flag_z, flag_n, flag_v} !== 5'b01010) begin n_err++; $display("FAIL flush_full got %b%b/%b%b%b want 01/010", out_valid, in_ready, flag_z, flag_n, flag_v); end
    n_vec++; if (stall_cnt !== 16'(m_stall)) begin n_err++; $display("FAIL flush_stall got %0d want %0d", stall_cnt, m_stall); end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
            3'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
      tick();
      n_vec++; if ({out_valid, in_ready, flag_z, flag_n, flag_v, stall_cnt} !== {q.size() > 0, q.size() < 2, m_flags, 16'(m_stall)})
        begin n_err++; $display("FAIL rand_ctrl cyc %0d got %b%b/%b%b%b/%0d want %b%b/%b/%0d", i, out_valid, in_ready, flag_z, flag_n, flag_v, stall_cnt, q.size() > 0, q.size() < 2, m_flags, m_stall); end
      if (q.size() > 0) begin
        n_vec++; if ({out_result, out_rd, out_reg_write} !== q[0]) begin n_err++; $display("FAIL rand_data cyc %0d got %h/%0d/%b want %h/%0d/%b", i, out_result, out_rd, out_reg_write, q[0].r, q[0].rd, q[0].w); end
      end
    end
  endtask
  task automatic test_saturate();
    do_reset();
    drive(1, 32'hC0DE, 9, 1, 1, 3'b111, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (65536 + 5) @(posedge clk);
    @(negedge clk);
    n_vec++; if ({stall_cnt, out_valid, out_result} !== {16'hFFFF, 1'b1, 32'hC0DE}) begin n_err++; $display("FAIL sat_count got %h/%b/%h want ffff/1/0000c0de", stall_cnt, out_valid, out_result); end
    rst = 1;
    #1;
    n_vec++; if ({out_valid, out_result, out_rd, out_reg_write, flag_z, flag_n, flag_v, stall_cnt, in_ready} !== 59'd1)
      begin n_err++; $display("FAIL async_reset got %b/%h/%h/%b/%b%b%b/%h/%b want zeros, in_ready 1", out_valid, out_result, out_rd, out_reg_write, flag_z, flag_n, flag_v, stall_cnt, in_ready); end
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flags();
    test_flush();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
